// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the trap sequencer.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_t;

  localparam int MCAUSE_CODE_W = 4;

  localparam logic [31:0] TRAP_CAUSE_MTI = 32'h8000_0007;

  localparam logic [3:0] EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT    = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR  = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;
  localparam logic [3:0] EXC_ECALL_U        = 4'd8;
  localparam logic [3:0] EXC_ECALL_S        = 4'd9;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;

  // Synchronous exception cause: the code zero-extended to the mcause width.
  function automatic logic [31:0] exc_cause32(input logic [3:0] code);
    return {28'b0, code};
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit, CSR and fetch-redirect signals of the trap sequencer.
// master = pipeline/CSR/fetch side, slave = trap_ctrl.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_next_pc;
  logic            commit_exc;
  logic [3:0]      commit_exc_code;
  logic [XLEN-1:0] commit_tval;
  logic            commit_mret;

  logic            timer_irq;
  logic            mstatus_mie;
  logic            mie_mtie;
  logic [XLEN-1:0] mtvec;
  logic [XLEN-1:0] mepc;

  logic            trap_enter;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_val;
  logic            mret_exec;
  logic            flush;
  logic            busy;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output commit_valid, commit_pc, commit_next_pc, commit_exc,
           commit_exc_code, commit_tval, commit_mret,
           timer_irq, mstatus_mie, mie_mtie, mtvec, mepc, redirect_ready,
    input  trap_enter, trap_cause, trap_pc, trap_val, mret_exec,
           flush, busy, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_next_pc, commit_exc,
           commit_exc_code, commit_tval, commit_mret,
           timer_irq, mstatus_mie, mie_mtie, mtvec, mepc, redirect_ready,
    output trap_enter, trap_cause, trap_pc, trap_val, mret_exec,
           flush, busy, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_ctrl_irq_sync.sv
// Timer interrupt synchronizer plus MTIE/MIE enable gating.
// The enables come from local CSRs and are used unsynchronized.
module trap_irq_sync #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic mstatus_mie_i,
  input  logic mie_mtie_i,
  output logic irq_pend_o
);

  logic irq_s;

  generate
    if (STAGES == 0) begin : g_raw
      assign irq_s = irq_i;
    end else begin : g_sync
      logic [STAGES-1:0] sync_q;

      // Shift the raw interrupt level through the flop chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= irq_i;
          for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign irq_s = sync_q[STAGES-1];
    end
  endgenerate

  assign irq_pend_o = irq_s & mie_mtie_i & mstatus_mie_i;

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer between commit and the M-mode CSR file.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a commit; accepts exc > mret > irq (flush Mealy)
// COMMIT   | one-cycle trap_enter or mret_exec strobe, latch target
// REDIRECT | redirect_valid held until fetch raises redirect_ready
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int IRQ_SYNC_STAGES = 1
) (
  input  logic       clk,
  input  logic       rst,
  trap_ctrl_if.slave bus
);

  localparam logic [XLEN-1:0] CAUSE_MTI =
    {1'b1, {(XLEN-1-MCAUSE_CODE_W){1'b0}}, TRAP_CAUSE_MTI[MCAUSE_CODE_W-1:0]};

  trap_state_t     state_q, state_d;
  trap_kind_t      kind_q, kind_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] val_q, val_d;
  logic [XLEN-1:0] target_q, target_d;

  logic irq_pend;
  logic flush;
  logic trap_enter;
  logic mret_exec;
  logic redirect_valid;

  trap_irq_sync #(
    .STAGES(IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk          (clk),
    .rst          (rst),
    .irq_i        (bus.timer_irq),
    .mstatus_mie_i(bus.mstatus_mie),
    .mie_mtie_i   (bus.mie_mtie),
    .irq_pend_o   (irq_pend)
  );

  // State and latched trap information.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      kind_q   <= KIND_TRAP;
      cause_q  <= '0;
      pc_q     <= '0;
      val_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cause_q  <= cause_d;
      pc_q     <= pc_d;
      val_q    <= val_d;
      target_q <= target_d;
    end
  end

  // Next-state, acceptance arbitration and strobe generation.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    cause_d        = cause_q;
    pc_d           = pc_q;
    val_d          = val_q;
    target_d       = target_q;
    flush          = 1'b0;
    trap_enter     = 1'b0;
    mret_exec      = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.commit_valid) begin
          if (bus.commit_exc) begin
            flush   = 1'b1;
            kind_d  = KIND_TRAP;
            cause_d = {{(XLEN-MCAUSE_CODE_W){1'b0}}, bus.commit_exc_code};
            pc_d    = bus.commit_pc;
            val_d   = bus.commit_tval;
            state_d = COMMIT;
          end else if (bus.commit_mret) begin
            // mret leaves the trap_* registers at their previous values.
            flush   = 1'b1;
            kind_d  = KIND_MRET;
            state_d = COMMIT;
          end else if (irq_pend) begin
            // The committing instruction retires; resume after it.
            flush   = 1'b1;
            kind_d  = KIND_TRAP;
            cause_d = CAUSE_MTI;
            pc_d    = bus.commit_next_pc;
            val_d   = '0;
            state_d = COMMIT;
          end
        end
      end

      COMMIT: begin
        flush      = 1'b1;
        trap_enter = (kind_q == KIND_TRAP);
        mret_exec  = (kind_q == KIND_MRET);
        target_d   = (kind_q == KIND_MRET) ? bus.mepc : bus.mtvec;
        state_d    = REDIRECT;
      end

      REDIRECT: begin
        redirect_valid = 1'b1;
        if (bus.redirect_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.flush          = flush;
  assign bus.trap_enter     = trap_enter;
  assign bus.mret_exec      = mret_exec;
  assign bus.trap_cause     = cause_q;
  assign bus.trap_pc        = pc_q;
  assign bus.trap_val       = val_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = target_q;

endmodule
